// File: rtl/debug_run_ctrl.sv
// Run-control for the debug path: generates the data_path pipeline enable for
// continuous, single-step, burst and run-to-breakpoint runs, and reports the
// stop cause and executed cycle count back to debug_unit.
module debug_run_ctrl #(
  parameter int unsigned NB_PC     = 32,
  parameter int unsigned NB_BP     = 4,
  parameter int unsigned NB_BP_IDX = 2,
  parameter int unsigned NB_CNT    = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [1:0]           i_mode,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [NB_CNT-1:0]    i_step_count,
  input  logic                 i_bp_wr,
  input  logic [NB_BP_IDX-1:0] i_bp_idx,
  input  logic [NB_PC-1:0]     i_bp_addr,
  input  logic                 i_bp_valid,
  input  logic [NB_PC-1:0]     i_pc,
  input  logic                 i_hlt,
  output logic                 o_pipeline_enable,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2:0]           o_stop_cause,
  output logic [NB_BP_IDX-1:0] o_bp_hit_idx,
  output logic [NB_CNT-1:0]    o_cycle_count
);

  localparam logic [1:0] MODE_NONE = 2'd0;
  localparam logic [1:0] MODE_CONT = 2'd1;
  localparam logic [1:0] MODE_STEP = 2'd2;

  localparam logic [2:0] CAUSE_NONE  = 3'd0;
  localparam logic [2:0] CAUSE_HALT  = 3'd1;
  localparam logic [2:0] CAUSE_BP    = 3'd2;
  localparam logic [2:0] CAUSE_COUNT = 3'd3;
  localparam logic [2:0] CAUSE_ABORT = 3'd4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_CONT = 2'd1,
    RUN_CNT  = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [NB_CNT-1:0]      remaining;
  logic                   first_cycle;
  logic [NB_PC-1:0]       bp_addr  [NB_BP];
  logic                   bp_valid [NB_BP];

  logic                   bp_hit_c;
  logic [NB_BP_IDX-1:0]   bp_idx_c;
  logic                   start_ok_c;
  logic                   run_enable_c;
  logic [2:0]             cause_c;

  // Lowest-index valid breakpoint slot matching the current fetch PC
  always_comb begin
    bp_hit_c = 1'b0;
    bp_idx_c = '0;
    for (int i = 0; i < NB_BP; i++) begin
      if (!bp_hit_c && bp_valid[i] && (bp_addr[i] == i_pc)) begin
        bp_hit_c = 1'b1;
        bp_idx_c = NB_BP_IDX'(i);
      end
    end
  end

  // Next-state, stop-condition priority and pipeline enable
  always_comb begin
    state_nxt    = state;
    start_ok_c   = 1'b0;
    run_enable_c = 1'b0;
    cause_c      = CAUSE_NONE;
    case (state)
      IDLE: begin
        if (i_start && (i_mode != MODE_NONE)) begin
          start_ok_c = 1'b1;
          state_nxt  = (i_mode == MODE_CONT) ? RUN_CONT : RUN_CNT;
        end
      end
      RUN_CONT, RUN_CNT: begin
        if (i_abort)                                   cause_c = CAUSE_ABORT;
        else if (i_hlt)                                cause_c = CAUSE_HALT;
        else if (bp_hit_c && !first_cycle)             cause_c = CAUSE_BP;
        else if ((state == RUN_CNT) && (remaining == '0)) cause_c = CAUSE_COUNT;
        if (cause_c != CAUSE_NONE) state_nxt    = DONE;
        else                       run_enable_c = 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_pipeline_enable = run_enable_c;

  // State register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Run bookkeeping: busy/done flags, counters and stop reporting
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_stop_cause  <= CAUSE_NONE;
      o_bp_hit_idx  <= '0;
      o_cycle_count <= '0;
      remaining     <= '0;
      first_cycle   <= 1'b0;
    end else begin
      o_busy <= (state_nxt == RUN_CONT) || (state_nxt == RUN_CNT);
      o_done <= (state_nxt == DONE);
      if (start_ok_c) begin
        o_cycle_count <= '0;
        o_stop_cause  <= CAUSE_NONE;
        first_cycle   <= 1'b1;
        remaining     <= (i_mode == MODE_STEP) ? NB_CNT'(1) : i_step_count;
      end
      if (run_enable_c) begin
        if (o_cycle_count != '1) o_cycle_count <= o_cycle_count + 1'b1;
        if (state == RUN_CNT)    remaining     <= remaining - 1'b1;
        first_cycle <= 1'b0;
      end
      if (cause_c != CAUSE_NONE) begin
        o_stop_cause <= cause_c;
        if (cause_c == CAUSE_BP) o_bp_hit_idx <= bp_idx_c;
      end
    end
  end

  // Breakpoint slot storage; out-of-range slot indices are dropped
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NB_BP; i++) begin
        bp_addr[i]  <= '0;
        bp_valid[i] <= 1'b0;
      end
    end else if (i_bp_wr && (32'(i_bp_idx) < NB_BP)) begin
      bp_addr[i_bp_idx]  <= i_bp_addr;
      bp_valid[i_bp_idx] <= i_bp_valid;
    end
  end

endmodule
